floppy_step_monitor: RTL

//  Receive-side decoder for the floppy STEP/DIR/SEL interface. It watches step,
//    dir and active-low select lines, which arrive asynchronously.

---
 rtl/floppy_step_monitor_if.sv | 37 +++
 rtl/floppy_step_monitor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/floppy_step_monitor_if.sv
// -----------------------------------------------------------------------------
// floppy_step_monitor_if
// Bundle of the floppy STEP/DIR/SEL lines plus the monitor's decoded outputs.
//   master : the side that drives the drive lines (a step generator or a bench)
//            and reads back the monitor results.
//   slave  : the floppy_step_monitor itself.
// Signals:
//   step_in, dir_in, sel_n_in : raw drive lines, asynchronous to clk
//   period                    : last measured STEP edge-to-edge interval, clks
//   period_valid              : 1-clk pulse whenever period updates
//   active                    : high while the monitor is tracking steady STEP
//   track                     : head position
//   dir_out, reversal         : synchronized DIR and its change pulse
// -----------------------------------------------------------------------------
interface floppy_step_monitor_if #(
  parameter int PERIOD_W = 22
);
  logic                step_in;
  logic                dir_in;
  logic                sel_n_in;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                active;
  logic [6:0]          track;
  logic                dir_out;
  logic                reversal;

  modport master (
    output step_in, dir_in, sel_n_in,
    input  period, period_valid, active, track, dir_out, reversal
  );

  modport slave (
    input  step_in, dir_in, sel_n_in,
    output period, period_valid, active, track, dir_out, reversal
  );
endinterface

// File: rtl/floppy_step_monitor.sv
// -----------------------------------------------------------------------------
// floppy_step_monitor
// Receive-side decoder for a floppy STEP/DIR/SEL interface. Measures the clk
// count between successive STEP toggles (either polarity), tracks head
// position from STEP falling edges and DIR, and flags reversals of DIR.
// Ports:
//   clk     : system clock, all logic on posedge
//   rst_n   : asynchronous active-low reset
//   io_mon  : floppy_step_monitor_if.slave (drive lines in, decoded results out)
// Parameters:
//   PERIOD_W   : width of the measured period / interval counter
//   TRACKS     : number of tracks; position saturates at 0 and TRACKS-1
//   IDLE_LIMIT : clks without a STEP edge before falling back to IDLE
// -----------------------------------------------------------------------------
module floppy_step_monitor #(
  parameter int PERIOD_W   = 22,
  parameter int TRACKS     = 80,
  parameter int IDLE_LIMIT = 4_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  floppy_step_monitor_if.slave   io_mon
);

  localparam logic [PERIOD_W-1:0] LIMIT_CNT = PERIOD_W'(IDLE_LIMIT);
  localparam logic [6:0]          TRACK_MAX = 7'(TRACKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_TRACKING = 2'd2
  } state_t;

  function automatic logic [6:0] track_inc(input logic [6:0] t);
    return (t >= TRACK_MAX) ? TRACK_MAX : t + 7'd1;
  endfunction

  function automatic logic [6:0] track_dec(input logic [6:0] t);
    return (t == 7'd0) ? 7'd0 : t - 7'd1;
  endfunction

  // Synchronizers
  logic r_step_s1, r_step_s2, r_step_s3;
  logic r_dir_s1,  r_dir_s2;
  logic r_sel_s1,  r_sel_s2;

  // Event stage: registered edge flags and the DIR that applies to a fall
  logic r_edge_p1, r_fall_p1, r_fall_dir_p1;

  logic                r_dir_out, r_reversal;
  logic [6:0]          r_track;
  logic [PERIOD_W-1:0] r_cnt, r_period;
  logic                r_period_valid;

  state_t r_state, w_state_next;

  logic w_step_edge, w_step_fall, w_selected, w_at_limit;
  logic w_active, w_measure, w_restart;

  assign w_step_edge = r_step_s2 ^ r_step_s3;
  assign w_step_fall = ~r_step_s2 & r_step_s3;
  assign w_selected  = ~r_sel_s2;
  assign w_at_limit  = (r_cnt == LIMIT_CNT);

  // ---- stage s1/s2/s3: input synchronization ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_step_s3 <= 1'b0;
      r_dir_s1  <= 1'b1;
      r_dir_s2  <= 1'b1;
      r_sel_s1  <= 1'b0;
      r_sel_s2  <= 1'b0;
    end else begin
      r_step_s1 <= io_mon.step_in;
      r_step_s2 <= r_step_s1;
      r_step_s3 <= r_step_s2;
      r_dir_s1  <= io_mon.dir_in;
      r_dir_s2  <= r_dir_s1;
      r_sel_s1  <= io_mon.sel_n_in;
      r_sel_s2  <= r_sel_s1;
    end
  end

  // ---- stage p1: edge events and DIR tracking ----
  // r_dir_out still holds the pre-change DIR in the clk a new DIR arrives,
  // so a fall captured together with a DIR change uses the old direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_p1     <= 1'b0;
      r_fall_p1     <= 1'b0;
      r_fall_dir_p1 <= 1'b1;
      r_dir_out     <= 1'b1;
      r_reversal    <= 1'b0;
    end else begin
      r_edge_p1     <= w_step_edge;
      r_fall_p1     <= w_step_fall;
      r_fall_dir_p1 <= r_dir_out;
      r_dir_out     <= r_dir_s2;
      r_reversal    <= (r_dir_s2 != r_dir_out);
    end
  end

  // ---- stage p2: FSM, counter, period and track ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Deselect beats an edge; an edge beats the idle timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_selected && r_edge_p1) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (!w_selected)     w_state_next = ST_IDLE;
        else if (r_edge_p1)  w_state_next = ST_TRACKING;
        else if (w_at_limit) w_state_next = ST_IDLE;
      end
      ST_TRACKING: begin
        if (!w_selected)     w_state_next = ST_IDLE;
        else if (r_edge_p1)  w_state_next = ST_TRACKING;
        else if (w_at_limit) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_active  = (r_state == ST_TRACKING);
    w_restart = w_selected & r_edge_p1;
    w_measure = w_restart & (r_state != ST_IDLE);
  end

  // cnt is 1 in the clk after an accepted edge, so edges N clks apart
  // read cnt==N; it never passes LIMIT_CNT because that forces IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      if (w_state_next == ST_IDLE) r_cnt <= '0;
      else if (w_restart)          r_cnt <= PERIOD_W'(1);
      else                         r_cnt <= r_cnt + PERIOD_W'(1);
      if (w_measure) r_period <= r_cnt;
      r_period_valid <= w_measure;
    end
  end

  // Position follows falls regardless of select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_track <= 7'd0;
    end else if (r_fall_p1) begin
      r_track <= r_fall_dir_p1 ? track_dec(r_track) : track_inc(r_track);
    end
  end

  assign io_mon.period       = r_period;
  assign io_mon.period_valid = r_period_valid;
  assign io_mon.active       = w_active;
  assign io_mon.track        = r_track;
  assign io_mon.dir_out      = r_dir_out;
  assign io_mon.reversal     = r_reversal;

endmodule
